// File: rtl/rr_bus_arbiter.sv
// N-way shared-bus arbiter: round-robin or fixed-priority selection, grant held
// while the owner keeps requesting, with optional hold-limit preemption under contention.
module rr_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mode,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               hold_expired
);

    // MAX_HOLD=0 disables preemption; keep a 1-bit counter so the width never collapses
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] pool;
    logic               own_req;
    logic [ID_W-1:0]    pick;
    logic               do_grant;
    logic               do_drop;
    logic               do_expire;
    logic [CNT_W-1:0]   cnt_next;

    // Rotate the pool so rr_ptr lands on bit 0, take the lowest set bit, then un-rotate.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] p,
                                                input logic [ID_W-1:0]    ptr);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [ID_W-1:0]      sel;
        logic                 found;
        dbl   = {p, p} >> ptr;
        rot   = dbl[NUM_REQ-1:0];
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                sel   = ID_W'((int'(ptr) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ID_W-1:0] fixed_pick(input logic [NUM_REQ-1:0] p);
        logic [ID_W-1:0] sel;
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (p[i]) begin
                sel = ID_W'(i);
            end
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        return v << id;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return ID_W'((int'(id) + 1) % NUM_REQ);
    endfunction

    always_comb begin
        others    = req & ~grant;
        own_req   = |(req & grant);
        pool      = (state == IDLE) ? req : others;
        pick      = mode ? fixed_pick(pool) : rr_pick(pool, rr_ptr);
        do_grant  = 1'b0;
        do_drop   = 1'b0;
        do_expire = 1'b0;
        cnt_next  = '0;
        case (state)
            IDLE: begin
                do_grant = |req;
            end
            GRANT: begin
                if (own_req) begin
                    if (others != '0) begin
                        if ((MAX_HOLD > 0) && (hold_cnt == CNT_LAST)) begin
                            do_grant  = 1'b1;
                            do_expire = 1'b1;
                        end else begin
                            cnt_next = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
                        end
                    end
                end else if (others != '0) begin
                    // owner released with others waiting: hand off with no idle gap
                    do_grant = 1'b1;
                end else begin
                    do_drop = 1'b1;
                end
            end
            default: begin
                do_drop = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            hold_expired <= 1'b0;
            hold_cnt     <= '0;
            rr_ptr       <= '0;
        end else begin
            hold_cnt     <= cnt_next;
            hold_expired <= do_expire;
            if (do_grant) begin
                state       <= GRANT;
                grant       <= to_onehot(pick);
                grant_valid <= 1'b1;
                grant_id    <= pick;
                rr_ptr      <= next_ptr(pick);
            end else if (do_drop) begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_id    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed table-driven bench for rr_bus_arbiter (NUM_REQ=4, MAX_HOLD=4).
module tb_rr_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       hold_expired;

    int tests;
    int fails;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
        logic       hx;
    } vec_t;

    vec_t vecs[$];

    rr_bus_arbiter #(
        .NUM_REQ (4),
        .MAX_HOLD(4),
        .ID_W    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mode        (mode),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .hold_expired(hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic m, input logic [3:0] rq,
                       input logic [3:0] g, input logic [1:0] id, input logic hx);
        vec_t v;
        v.rst  = r;
        v.mode = m;
        v.req  = rq;
        v.g    = g;
        v.id   = id;
        v.hx   = hx;
        vecs.push_back(v);
    endtask

    task automatic addn(input int n, input logic r, input logic m, input logic [3:0] rq,
                        input logic [3:0] g, input logic [1:0] id, input logic hx);
        for (int k = 0; k < n; k++) add(r, m, rq, g, id, hx);
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic ehx);
        logic ev;
        ev = (eg != 4'b0000);
        tests++;
        if (grant !== eg || grant_valid !== ev || grant_id !== eid || hold_expired !== ehx) begin
            fails++;
            $display("FAIL %s: got grant=%b valid=%b id=%0d hx=%b, want grant=%b valid=%b id=%0d hx=%b",
                     name, grant, grant_valid, grant_id, hold_expired, eg, ev, eid, ehx);
        end
    endtask

    initial begin
        int waited;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        mode  = 1'b0;
        req   = 4'b0000;

        // reset with requests pending, then 1-cycle grant latency
        addn(2, 1, 0, 4'b0101, 4'b0000, 0, 0);
        add (0, 0, 4'b0101, 4'b0001, 0, 0);
        // hold counter clears on an uncontended cycle
        addn(2, 0, 0, 4'b1111, 4'b0001, 0, 0);
        add (0, 0, 4'b0001, 4'b0001, 0, 0);
        addn(3, 0, 0, 4'b1111, 4'b0001, 0, 0);
        add (0, 0, 4'b1111, 4'b0010, 1, 1);
        // round-robin rotation with preemption every 4 contended cycles
        addn(3, 0, 0, 4'b1111, 4'b0010, 1, 0);
        add (0, 0, 4'b1111, 4'b0100, 2, 1);
        addn(3, 0, 0, 4'b1111, 4'b0100, 2, 0);
        add (0, 0, 4'b1111, 4'b1000, 3, 1);
        addn(3, 0, 0, 4'b1111, 4'b1000, 3, 0);
        add (0, 0, 4'b1111, 4'b0001, 0, 1);
        addn(3, 0, 0, 4'b1111, 4'b0001, 0, 0);
        add (0, 0, 4'b1111, 4'b0010, 1, 1);
        // owner 1 releases with req2 pending: direct handoff, then idle
        add (0, 0, 4'b0100, 4'b0100, 2, 0);
        add (0, 0, 4'b0000, 4'b0000, 0, 0);
        // single requester (rr_ptr=3 wraps to 0), never preempted
        addn(20, 0, 0, 4'b0001, 4'b0001, 0, 0);
        // owner 0 releases with req2 pending
        add (0, 0, 4'b0100, 4'b0100, 2, 0);
        add (0, 0, 4'b0000, 4'b0000, 0, 0);
        // fixed priority from idle with rr_ptr=3: lowest index wins, req3 starved
        add (0, 1, 4'b1110, 4'b0010, 1, 0);
        addn(3, 0, 1, 4'b1110, 4'b0010, 1, 0);
        add (0, 1, 4'b1110, 4'b0100, 2, 1);
        addn(3, 0, 1, 4'b1110, 4'b0100, 2, 0);
        add (0, 1, 4'b1110, 4'b0010, 1, 1);
        addn(3, 0, 1, 4'b1110, 4'b0010, 1, 0);
        add (0, 1, 4'b1110, 4'b0100, 2, 1);
        // reset mid-grant; rr_ptr back to 0
        add (1, 0, 4'b1111, 4'b0000, 0, 0);
        add (0, 0, 4'b1111, 4'b0001, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].rst;
            mode = vecs[i].mode;
            req  = vecs[i].req;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].hx);
        end

        // owner and all others release: grant drops to idle
        req = 4'b0000;
        @(posedge clk);
        #1;
        check("drop_idle", 4'b0000, 0, 0);

        // bounded wait for a grant to req3; must arrive after exactly one edge
        req    = 4'b1000;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!grant_valid && waited < 5);
        tests++;
        if (waited != 1) begin
            fails++;
            $display("FAIL grant_latency: got %0d cycles, want 1", waited);
        end
        check("grant_req3", 4'b1000, 3, 0);

        // grant persists for the cycle in which req falls, then drops
        req = 4'b0000;
        @(negedge clk);
        check("release_hold", 4'b1000, 3, 0);
        @(posedge clk);
        #1;
        check("release_drop", 4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
